// File: rtl/maxpool_stream_ctrl.sv
// Streaming 2x2 stride-2 max-pool sequencer.
// Pixels arrive in raster order (channel, row, column). A pair register holds
// the even-column pixel, a half-width line buffer holds the horizontal pair
// maxima of the even row, and the odd-row/odd-column pixel completes a window
// whose maximum is loaded into a valid/ready output register.
module maxpool_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 28,
  parameter int InputW     = 28,
  parameter int Depth      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int HalfW = InputW / 2;
  localparam int ColW  = $clog2(InputW);
  localparam int RowW  = $clog2(InputH);
  localparam int ChW   = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateE;

  stateE                 stateReg;
  stateE                 stateNext;
  logic [ColW-1:0]       colReg;
  logic [RowW-1:0]       rowReg;
  logic [ChW-1:0]        chReg;
  logic [DATA_WIDTH-1:0] pairReg;
  logic [DATA_WIDTH-1:0] lineBuf [HalfW];
  logic [DATA_WIDTH-1:0] outDataReg;
  logic                  outValidReg;

  logic [ColW-1:0]       halfCol;
  logic [DATA_WIDTH-1:0] lineRd;
  logic [DATA_WIDTH-1:0] pairMax;
  logic [DATA_WIDTH-1:0] windowMax;
  logic                  accept;
  logic                  completing;
  logic                  lastCol;
  logic                  lastRow;
  logic                  lastCh;

  // Signed maximum; on a tie both operands are equal, so either is correct.
  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign halfCol    = colReg >> 1;
  assign completing = rowReg[0] & colReg[0];
  assign lastCol    = (colReg == ColW'(InputW - 1));
  assign lastRow    = (rowReg == RowW'(InputH - 1));
  assign lastCh     = (chReg == ChW'(Depth - 1));
  assign accept     = in_valid & in_ready;
  assign pairMax    = smax(pairReg, in_data);
  assign windowMax  = smax(lineRd, pairMax);

  assign out_data  = outDataReg;
  assign out_valid = outValidReg;
  assign busy      = (stateReg != IDLE);

  // Line buffer read: select the entry for the current column pair.
  always_comb begin
    lineRd = '0;
    for (int i = 0; i < HalfW; i++) begin
      if (halfCol == ColW'(i)) begin
        lineRd = lineBuf[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state, input handshake and end-of-frame pulse.
  always_comb begin
    stateNext = stateReg;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        // Only the window-completing pixel can be blocked by a full output.
        in_ready = ~completing | ~outValidReg | out_ready;
        if (in_valid && in_ready && lastCol && lastRow && lastCh) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (~outValidReg | out_ready) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Column/row/channel counters advance once per accepted pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      colReg <= '0;
      rowReg <= '0;
      chReg  <= '0;
    end else if (stateReg == IDLE && start) begin
      colReg <= '0;
      rowReg <= '0;
      chReg  <= '0;
    end else if (accept) begin
      if (lastCol) begin
        colReg <= '0;
        if (lastRow) begin
          rowReg <= '0;
          chReg  <= lastCh ? '0 : chReg + ChW'(1);
        end else begin
          rowReg <= rowReg + RowW'(1);
        end
      end else begin
        colReg <= colReg + ColW'(1);
      end
    end
  end

  // Pair register captures the even-column pixel of each horizontal pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      pairReg <= '0;
    end else if (accept && !colReg[0]) begin
      pairReg <= in_data;
    end
  end

  // Line buffer entries: even-row pair maxima, one register per column pair.
  generate
    for (genvar gi = 0; gi < HalfW; gi++) begin : gLineBuf
      always_ff @(posedge clk) begin
        if (reset) begin
          lineBuf[gi] <= '0;
        end else if (accept && colReg[0] && !rowReg[0] && halfCol == ColW'(gi)) begin
          lineBuf[gi] <= pairMax;
        end
      end
    end
  endgenerate

  // Output register: load on window completion, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      outDataReg  <= '0;
      outValidReg <= 1'b0;
    end else if (accept && completing) begin
      outDataReg  <= windowMax;
      outValidReg <= 1'b1;
    end else if (out_ready) begin
      outValidReg <= 1'b0;
    end
  end

endmodule
